ddram_arbiter: RTL and testbench

Two-requester sequencer and arbiter for the MiSTer DDR3 (DDRAM_*) port. Port 0 is the CADR sdram/xbus word interface; port 1 is a secondary DMA-style requester (disk/microcode loader). The block arbitrates round-robin and issues one single-beat DDR transaction at a time. It maps 32-bit word addresses onto 64-bit DDR words with byte-enables, waits for read data with a timeout, and returns a one-cycle ack per request.

---
 rtl/ddram_arb_pkg.sv | 25 ++
 rtl/ddram_rr_pick.sv | 36 +++
 rtl/ddram_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_ddram_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddram_arb_pkg.sv
// ============================================================================
// Module   : ddram_arb_pkg
// Brief    : Shared types and constants for the two-port DDR3 arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ddram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef logic port_t;

    localparam logic [7:0] BE_LO     = 8'h0F;
    localparam logic [7:0] BE_HI     = 8'hF0;
    localparam logic [1:0] STALE_MAX = 2'd3;

endpackage

`default_nettype wire

// File: rtl/ddram_rr_pick.sv
// ============================================================================
// Module   : ddram_rr_pick
// Brief    : Two-way round-robin picker with a one-cycle holdoff on the last winner.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ddram_rr_pick
    import ddram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      last_grant,
    input  logic       holdoff,
    output logic       grant_valid,
    output port_t      grant_port
);

    logic [1:0] eligible;

    always_comb begin
        eligible = req;
        // The port just served may still show its old request level for one cycle.
        if (holdoff) begin
            eligible[last_grant] = 1'b0;
        end
        grant_valid = |eligible;
        if (&eligible) begin
            grant_port = ~last_grant;
        end else begin
            grant_port = eligible[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/ddram_arbiter.sv
// ============================================================================
// Module   : ddram_arbiter
// Brief    : Round-robin sequencer mapping two 32-bit word ports onto single-beat
//            64-bit DDR3 transactions, with read timeout and stale-data discard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ddram_arbiter
    import ddram_arb_pkg::*;
#(
    parameter logic [28:0] DDR_BASE = 29'h0,
    parameter int          TIMEOUT  = 1024,
    parameter logic [31:0] TMO_DATA = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [21:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p0_req,
    input  logic        p0_write,
    output logic [31:0] p0_rdata,
    output logic        p0_ack,

    input  logic [21:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic        p1_req,
    input  logic        p1_write,
    output logic [31:0] p1_rdata,
    output logic        p1_ack,

    output logic        DDRAM_CLK,
    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic        DDRAM_RD,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE,

    output logic        timeout_err
);

    localparam int               TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    port_t            grant_port;
    port_t            last_grant;
    logic             cur_write;
    logic             lane;
    logic             holdoff;
    logic [1:0]       stale_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    logic             pick_valid;
    port_t            pick_port;
    logic [21:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic             sel_write;
    logic             grant_fire;
    logic             accept;
    logic             capture;
    logic             tmo_fire;
    logic             discard;
    logic [31:0]      rd_word;

    ddram_rr_pick u_pick (
        .req         ({p1_req, p0_req}),
        .last_grant  (last_grant),
        .holdoff     (holdoff),
        .grant_valid (pick_valid),
        .grant_port  (pick_port)
    );

    assign sel_addr  = pick_port ? p1_addr  : p0_addr;
    assign sel_wdata = pick_port ? p1_wdata : p0_wdata;
    assign sel_write = pick_port ? p1_write : p0_write;

    assign DDRAM_CLK      = clk;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_RD       = (state == ISSUE) && !cur_write;
    assign DDRAM_WE       = (state == ISSUE) &&  cur_write;

    assign rd_word = lane ? DDRAM_DOUT[63:32] : DDRAM_DOUT[31:0];
    assign discard = DDRAM_DOUT_READY && (stale_cnt != 2'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_fire = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        tmo_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_fire = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                if (!DDRAM_BUSY) begin
                    accept    = 1'b1;
                    state_nxt = cur_write ? DONE : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (DDRAM_DOUT_READY && (stale_cnt == 2'd0)) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_fire  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_port  <= 1'b0;
            last_grant  <= 1'b1;
            cur_write   <= 1'b0;
            lane        <= 1'b0;
            holdoff     <= 1'b0;
            stale_cnt   <= 2'd0;
            tmo_cnt     <= '0;
            DDRAM_ADDR  <= '0;
            DDRAM_DIN   <= '0;
            DDRAM_BE    <= '0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
            p0_ack      <= 1'b0;
            p1_ack      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            holdoff <= (state == DONE);
            p0_ack  <= (state_nxt == DONE) && (grant_port == 1'b0);
            p1_ack  <= (state_nxt == DONE) && (grant_port == 1'b1);

            if (grant_fire) begin
                grant_port <= pick_port;
                last_grant <= pick_port;
                cur_write  <= sel_write;
                lane       <= sel_addr[0];
                DDRAM_ADDR <= DDR_BASE + {8'd0, sel_addr[21:1]};
                DDRAM_DIN  <= {sel_wdata, sel_wdata};
                DDRAM_BE   <= sel_addr[0] ? BE_HI : BE_LO;
            end

            if (accept) begin
                tmo_cnt <= '0;
            end else if (state == WAIT_RD) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (capture || tmo_fire) begin
                if (grant_port) begin
                    p1_rdata <= capture ? rd_word : TMO_DATA;
                end else begin
                    p0_rdata <= capture ? rd_word : TMO_DATA;
                end
            end

            if (tmo_fire) begin
                timeout_err <= 1'b1;
            end

            // A timed-out read leaves one DDR response in flight; count it so it is dropped.
            if (discard && !tmo_fire) begin
                stale_cnt <= stale_cnt - 2'd1;
            end else if (tmo_fire && !discard && (stale_cnt != STALE_MAX)) begin
                stale_cnt <= stale_cnt + 2'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ddram_arbiter.sv
// ============================================================================
// Module   : tb_ddram_arbiter
// Brief    : Scoreboard bench for ddram_arbiter: queued expected acks and DDR commands.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ddram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [21:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_req, p1_req, p0_write, p1_write;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_ack, p1_ack;
    logic        ddram_clk;
    logic        busy;
    logic [7:0]  burstcnt;
    logic [28:0] ddr_addr;
    logic [63:0] dout;
    logic        dout_ready;
    logic        ddr_rd;
    logic [63:0] ddr_din;
    logic [7:0]  ddr_be;
    logic        ddr_we;
    logic        timeout_err;

    ddram_arbiter #(
        .DDR_BASE (29'h0),
        .TIMEOUT  (16),
        .TMO_DATA (32'hFFFF_FFFF)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .p0_addr          (p0_addr),
        .p0_wdata         (p0_wdata),
        .p0_req           (p0_req),
        .p0_write         (p0_write),
        .p0_rdata         (p0_rdata),
        .p0_ack           (p0_ack),
        .p1_addr          (p1_addr),
        .p1_wdata         (p1_wdata),
        .p1_req           (p1_req),
        .p1_write         (p1_write),
        .p1_rdata         (p1_rdata),
        .p1_ack           (p1_ack),
        .DDRAM_CLK        (ddram_clk),
        .DDRAM_BUSY       (busy),
        .DDRAM_BURSTCNT   (burstcnt),
        .DDRAM_ADDR       (ddr_addr),
        .DDRAM_DOUT       (dout),
        .DDRAM_DOUT_READY (dout_ready),
        .DDRAM_RD         (ddr_rd),
        .DDRAM_DIN        (ddr_din),
        .DDRAM_BE         (ddr_be),
        .DDRAM_WE         (ddr_we),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } ack_t;

    typedef struct {
        bit          we;
        logic [28:0] addr;
        logic [7:0]  be;
        logic [63:0] din;
        bit          chk_din;
    } cmd_t;

    ack_t        ack_q[$];
    cmd_t        cmd_q[$];
    ack_t        e;
    cmd_t        c;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_rd0 = '0;
    logic [31:0] m_rd1 = '0;
    int          rd_cycles = 0;
    int          unstable  = 0;
    logic        prev_rd   = 1'b0;
    logic [28:0] prev_addr = '0;
    logic [7:0]  prev_be   = '0;
    int          lat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ack(input bit port);
        ack_t a;
        a.port = port;
        a.rd0  = m_rd0;
        a.rd1  = m_rd1;
        ack_q.push_back(a);
    endtask

    task automatic push_cmd(input bit we, input logic [28:0] a, input logic [7:0] be,
                            input logic [63:0] din);
        cmd_t x;
        x.we      = we;
        x.addr    = a;
        x.be      = be;
        x.din     = din;
        x.chk_din = we;
        cmd_q.push_back(x);
    endtask

    // Monitor: compares every ack and every accepted DDR command with the queues.
    always @(negedge clk) begin
        if (p0_ack || p1_ack) begin
            if (ack_q.size() == 0) begin
                chk("unexpected_ack", {62'd0, p1_ack, p0_ack}, 64'd0);
            end else begin
                e = ack_q.pop_front();
                chk("ack_port", {62'd0, p1_ack, p0_ack}, e.port ? 64'd2 : 64'd1);
                chk("p0_rdata", {32'd0, p0_rdata}, {32'd0, e.rd0});
                chk("p1_rdata", {32'd0, p1_rdata}, {32'd0, e.rd1});
            end
        end
        if ((ddr_rd || ddr_we) && !busy) begin
            if (cmd_q.size() == 0) begin
                chk("unexpected_cmd", {62'd0, ddr_we, ddr_rd}, 64'd0);
            end else begin
                c = cmd_q.pop_front();
                chk("cmd_kind", {62'd0, ddr_we, ddr_rd}, c.we ? 64'd2 : 64'd1);
                chk("cmd_addr", {35'd0, ddr_addr}, {35'd0, c.addr});
                chk("cmd_be", {56'd0, ddr_be}, {56'd0, c.be});
                if (c.chk_din) chk("cmd_din", ddr_din, c.din);
            end
        end
        if (ddr_rd) begin
            rd_cycles++;
            if (prev_rd && (ddr_addr != prev_addr || ddr_be != prev_be)) unstable++;
        end
        prev_rd   = ddr_rd;
        prev_addr = ddr_addr;
        prev_be   = ddr_be;
    end

    task automatic do_req(input bit port, input logic [21:0] a, input logic w,
                          input logic [31:0] d, output int l);
        @(posedge clk); #1;
        if (port) begin
            p1_addr = a; p1_write = w; p1_wdata = d; p1_req = 1'b1;
        end else begin
            p0_addr = a; p0_write = w; p0_wdata = d; p0_req = 1'b1;
        end
        l = 0;
        while (1) begin
            @(negedge clk);
            l++;
            if (port ? p1_ack : p0_ack) break;
            if (l > 200) begin
                chk("ack_timeout", 64'(l), 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
        if (port) p1_req = 1'b0;
        else      p0_req = 1'b0;
    endtask

    task automatic wait_rd_accept();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ddr_rd && !busy) && n < 300);
        if (n >= 300) chk("rd_accept_timeout", 64'(n), 64'd0);
    endtask

    task automatic ddr_reply(input int dly, input logic [63:0] d, input bit junk_first);
        wait_rd_accept();
        if (junk_first) begin
            @(posedge clk); #1;
            dout = 64'hDEAD_BEEF_DEAD_BEEF; dout_ready = 1'b1;
            @(posedge clk); #1;
            dout_ready = 1'b0;
        end
        repeat (dly) @(posedge clk);
        #1;
        dout = d; dout_ready = 1'b1;
        @(posedge clk); #1;
        dout_ready = 1'b0; dout = '0;
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int la, lb;
        reset_n = 1'b0;
        p0_addr = '0; p0_wdata = '0; p0_req = 1'b0; p0_write = 1'b0;
        p1_addr = '0; p1_wdata = '0; p1_req = 1'b0; p1_write = 1'b0;
        busy = 1'b0; dout = '0; dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd", {62'd0, ddr_we, ddr_rd}, 64'd0);
        chk("rst_addr_be", {27'd0, ddr_addr, ddr_be}, 64'd0);
        chk("rst_din", ddr_din, 64'd0);
        chk("rst_acks_err", {61'd0, timeout_err, p1_ack, p0_ack}, 64'd0);
        chk("rst_rdata", {p1_rdata, p0_rdata}, 64'd0);
        chk("burstcnt", {56'd0, burstcnt}, 64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Both ports request continuously from reset: grants must alternate 0,1,0,1.
        push_cmd(1'b1, 29'h80,     8'h0F, 64'hA0A00001_A0A00001); push_ack(1'b0);
        push_cmd(1'b1, 29'h100,    8'hF0, 64'hB1B10002_B1B10002); push_ack(1'b1);
        push_cmd(1'b1, 29'h1FFFFF, 8'hF0, 64'hC0C00003_C0C00003); push_ack(1'b0);
        push_cmd(1'b1, 29'h1,      8'h0F, 64'hD1D10004_D1D10004); push_ack(1'b1);
        fork
            begin
                do_req(1'b0, 22'h000100, 1'b1, 32'hA0A0_0001, la);
                do_req(1'b0, 22'h3FFFFF, 1'b1, 32'hC0C0_0003, la);
            end
            begin
                do_req(1'b1, 22'h000201, 1'b1, 32'hB1B1_0002, lb);
                do_req(1'b1, 22'h000002, 1'b1, 32'hD1D1_0004, lb);
            end
        join

        // Single p0 write, odd address -> upper lane.
        push_cmd(1'b1, 29'h1, 8'hF0, 64'h12345678_12345678); push_ack(1'b0);
        do_req(1'b0, 22'h000003, 1'b1, 32'h1234_5678, lat);
        chk("write_latency", 64'(lat), 64'd3);

        // p1 read, DDR answers 5 cycles after acceptance.
        push_cmd(1'b0, 29'h8, 8'h0F, 64'd0);
        m_rd1 = 32'hCCCC_DDDD; push_ack(1'b1);
        fork
            do_req(1'b1, 22'h000010, 1'b0, 32'h0, lat);
            ddr_reply(5, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
        join
        chk("read_latency", 64'(lat), 64'd8);

        // BUSY high for 7 ISSUE cycles: RD held for 8 with stable address/BE.
        busy = 1'b1;
        rd_cycles = 0;
        unstable  = 0;
        push_cmd(1'b0, 29'h10, 8'hF0, 64'd0);
        m_rd0 = 32'h1111_2222; push_ack(1'b0);
        fork
            do_req(1'b0, 22'h000021, 1'b0, 32'h0, lat);
            begin
                int n = 0;
                do begin @(negedge clk); n++; end while (!ddr_rd && n < 100);
                repeat (7) @(posedge clk);
                #1 busy = 1'b0;
            end
            ddr_reply(2, 64'h1111_2222_3333_4444, 1'b0);
        join
        chk("busy_rd_cycles", 64'(rd_cycles), 64'd8);
        chk("busy_rd_stable", 64'(unstable), 64'd0);
        chk("busy_latency", 64'(lat), 64'd12);

        // Read timeout, then a read whose WAIT_RD sees the late response first.
        push_cmd(1'b0, 29'h2, 8'h0F, 64'd0);
        m_rd0 = 32'hFFFF_FFFF; push_ack(1'b0);
        do_req(1'b0, 22'h000004, 1'b0, 32'h0, lat);
        chk("timeout_latency", 64'(lat), 64'd19);
        chk("timeout_err_set", {63'd0, timeout_err}, 64'd1);
        push_cmd(1'b0, 29'h2, 8'hF0, 64'd0);
        m_rd0 = 32'h5555_6666; push_ack(1'b0);
        fork
            do_req(1'b0, 22'h000005, 1'b0, 32'h0, lat);
            ddr_reply(2, 64'h5555_6666_7777_8888, 1'b1);
        join
        chk("stale_latency", 64'(lat), 64'd7);
        chk("timeout_err_sticky", {63'd0, timeout_err}, 64'd1);

        // Reset while waiting for read data.
        push_cmd(1'b0, 29'h4, 8'h0F, 64'd0);
        @(posedge clk); #1;
        p0_addr = 22'h000008; p0_write = 1'b0; p0_req = 1'b1;
        wait_rd_accept();
        @(posedge clk); #1;
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("arst_cmd", {62'd0, ddr_we, ddr_rd}, 64'd0);
        chk("arst_addr_be", {27'd0, ddr_addr, ddr_be}, 64'd0);
        chk("arst_din", ddr_din, 64'd0);
        chk("arst_acks_err", {61'd0, timeout_err, p1_ack, p0_ack}, 64'd0);
        chk("arst_rdata", {p1_rdata, p0_rdata}, 64'd0);
        m_rd0 = '0; m_rd1 = '0;
        p0_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        dout = 64'hBAD0_BAD0_BAD0_BAD0; dout_ready = 1'b1;
        @(posedge clk); #1;
        dout_ready = 1'b0; dout = '0;
        push_cmd(1'b0, 29'h4, 8'hF0, 64'd0);
        m_rd0 = 32'h9999_AAAA; push_ack(1'b0);
        fork
            do_req(1'b0, 22'h000009, 1'b0, 32'h0, lat);
            ddr_reply(3, 64'h9999_AAAA_0000_1111, 1'b0);
        join
        chk("post_rst_err", {63'd0, timeout_err}, 64'd0);

        repeat (5) @(posedge clk);
        chk("ack_q_drained", 64'(ack_q.size()), 64'd0);
        chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
